// File: rtl/pc_pkg.sv
// Shared constants, state encoding and helpers for the PC fetch register slice.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_BAD  = 2'b11
  } pc_state_e;

  localparam int          INSN_BYTES   = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0080;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fsm.sv
// BOOT/RUN/HALT control FSM for the PC fetch register; run_en marks the RUN state.
module pc_fsm
  import pc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      halt,
  input  logic      resume,
  output pc_state_e state,
  output logic      run_en
);

  pc_state_e state_q;
  pc_state_e state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall never changes state; halt outranks resume so both high stays in HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume && !halt) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign state  = state_q;
  assign run_en = (state_q == ST_RUN);

endmodule

// File: rtl/pc_fetch_reg.sv
// Program-counter register with stall, halt/resume and misaligned-target trap.
// Optional fetch counter enabled by defining PC_FETCH_CNT_EN.
module pc_fetch_reg
  import pc_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = n'(DEF_RESET_PC),
  parameter logic [n-1:0] TRAP_VEC = n'(DEF_TRAP_VEC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] pc_next,
  input  logic         stall,
  input  logic         halt,
  input  logic         resume,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         fetch_valid,
  output logic         misalign_err,
`ifdef PC_FETCH_CNT_EN
  output logic [31:0]  fetch_cnt,
`endif
  output logic [1:0]   state
);

  // A misaligned trap vector would trap on itself forever.
  if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
    $error("pc_fetch_reg: TRAP_VEC must be word-aligned");
  end

  pc_state_e    fsm_state;
  logic         run_en;
  logic [n-1:0] pc_q;
  logic [n-1:0] pc_d;
  logic         err_q;
  logic         err_d;

  pc_fsm u_fsm (
    .clk    (clk),
    .rst    (rst),
    .halt   (halt),
    .resume (resume),
    .state  (fsm_state),
    .run_en (run_en)
  );

  // Halt beats stall beats update; a misaligned target redirects to the trap vector.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (run_en && !halt && !stall) begin
      if (is_word_aligned(pc_next[1:0])) begin
        pc_d = pc_next;
      end else begin
        pc_d  = TRAP_VEC;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + n'(INSN_BYTES);
  assign fetch_valid  = run_en && !stall;
  assign misalign_err = err_q;
  assign state        = fsm_state;

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (fetch_valid && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed self-checking bench for pc_fetch_reg with hand-computed expectations.
module tb_pc_fetch_reg;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign_err;
  logic [1:0]  state;
`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int passCount  = 0;
  int checkCount = 0;

  pc_fetch_reg dut (
    .clk          (clk),
    .rst          (rst),
    .pc_next      (pc_next),
    .stall        (stall),
    .halt         (halt),
    .resume       (resume),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .misalign_err (misalign_err),
`ifdef PC_FETCH_CNT_EN
    .fetch_cnt    (fetch_cnt),
`endif
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the edge happen and settle 1ns past it.
  task automatic applyStimulus(input logic [31:0] nxt, input logic st, input logic h, input logic r);
    pc_next = nxt;
    stall   = st;
    halt    = h;
    resume  = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seqPcs [4];

  initial begin
    seqPcs  = '{32'h4, 32'h8, 32'hC, 32'h10};
    rst     = 1'b1;
    pc_next = 32'h0;
    stall   = 1'b0;
    halt    = 1'b0;
    resume  = 1'b0;
    #3;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_fv", {31'd0, fetch_valid}, 32'd0);
    checkOutput("reset_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("reset_plus4", pc_plus4, 32'h4);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("boot_state", {30'd0, state}, 32'd0);
    checkOutput("boot_fv", {31'd0, fetch_valid}, 32'd0);

    // BOOT ignores halt: first edge must still reach RUN
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("run_state", {30'd0, state}, 32'd1);
    checkOutput("run_pc", pc, 32'h0);
    halt = 1'b0;
    #1;
    checkOutput("run_fv", {31'd0, fetch_valid}, 32'd1);
    checkOutput("run_plus4", pc_plus4, 32'h4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(pc_plus4, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("seq_pc%0d", i), pc, seqPcs[i]);
    end

    applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4, 32'h0);

    applyStimulus(32'h8, 1'b0, 1'b0, 1'b0);
    checkOutput("goto8", pc, 32'h8);

    stall = 1'b1;
    #1;
    checkOutput("stall_fv", {31'd0, fetch_valid}, 32'd0);
    applyStimulus(32'hC, 1'b1, 1'b0, 1'b0);
    checkOutput("stall1_pc", pc, 32'h8);
    applyStimulus(32'hC, 1'b1, 1'b0, 1'b0);
    checkOutput("stall2_pc", pc, 32'h8);
    checkOutput("stall2_fv", {31'd0, fetch_valid}, 32'd0);

    applyStimulus(32'hC, 1'b1, 1'b1, 1'b0);
    checkOutput("halt_state", {30'd0, state}, 32'd2);
    checkOutput("halt_pc", pc, 32'h8);
    stall = 1'b0;
    halt  = 1'b0;
    #1;
    checkOutput("halt_fv", {31'd0, fetch_valid}, 32'd0);

    applyStimulus(32'hC, 1'b0, 1'b1, 1'b1);
    checkOutput("halt_both", {30'd0, state}, 32'd2);
    applyStimulus(32'hC, 1'b1, 1'b0, 1'b1);
    checkOutput("resume_state", {30'd0, state}, 32'd1);
    checkOutput("resume_pc", pc, 32'h8);

    applyStimulus(32'h0000_0102, 1'b0, 1'b0, 1'b0);
    checkOutput("trap_pc", pc, 32'h80);
    checkOutput("trap_err", {31'd0, misalign_err}, 32'd1);
    applyStimulus(32'h200, 1'b0, 1'b0, 1'b0);
    checkOutput("post_trap_pc", pc, 32'h200);
    checkOutput("sticky_err", {31'd0, misalign_err}, 32'd1);
    applyStimulus(32'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("pc40", pc, 32'h40);

    // Asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("async_state", {30'd0, state}, 32'd0);
    #3;
    rst = 1'b0;
    checkOutput("reboot_fv", {31'd0, fetch_valid}, 32'd0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rerun_state", {30'd0, state}, 32'd1);
    checkOutput("rerun_plus4", pc_plus4, 32'h4);

    applyStimulus(32'h3, 1'b1, 1'b0, 1'b0);
    checkOutput("stallmask_pc", pc, 32'h0);
    checkOutput("stallmask_err", {31'd0, misalign_err}, 32'd0);
    applyStimulus(32'h3, 1'b0, 1'b1, 1'b0);
    checkOutput("haltmask_pc", pc, 32'h0);
    checkOutput("haltmask_err", {31'd0, misalign_err}, 32'd0);

`ifdef PC_FETCH_CNT_EN
    rst = 1'b1;
    #2;
    checkOutput("cnt_reset", fetch_cnt, 32'd0);
    rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_eight", fetch_cnt, 32'd8);
    @(negedge clk);
    force dut.fetch_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.fetch_cnt_q;
    for (int i = 0; i < 4; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_sat", fetch_cnt, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
